// File: rtl/alu_rs_pkg.sv
// Shared widths, constants and ALU op encodings for the ALU reservation station.
package alu_rs_pkg;

    localparam int TAG_WIDTH  = 5;
    localparam int OP_WIDTH   = 6;
    localparam int WORD_WIDTH = 32;
    localparam int REG_WIDTH  = 5;
    localparam int ADDR_WIDTH = 32;

    // Tag value meaning "operand present"; no in-flight producer is ever given it.
    localparam logic [TAG_WIDTH-1:0]  UNLOCKED = '0;
    localparam logic [WORD_WIDTH-1:0] ZERO     = '0;

    typedef enum logic [OP_WIDTH-1:0] {
        ALU_NOP   = 6'd0,
        ALU_ADD   = 6'd1,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_XOR,
        ALU_SLL,
        ALU_SRL,
        ALU_SRA,
        ALU_SLT,
        ALU_SLTU,
        ALU_LUI,
        ALU_AUIPC,
        ALU_JAL,
        ALU_JALR
    } alu_op_e;

endpackage

// File: rtl/alu_rs_if.sv
// Dispatch, writeback-broadcast and issue signals of the ALU reservation station.
interface alu_rs_if import alu_rs_pkg::*; #(
    parameter int TAG_W = TAG_WIDTH,
    parameter int OP_W  = OP_WIDTH
) ();

    logic                  rdy;
    logic                  flush;

    logic                  disp_en;
    logic [OP_W-1:0]       disp_op;
    logic [ADDR_WIDTH-1:0] disp_pc;
    logic [TAG_W-1:0]      disp_tagx;
    logic [TAG_W-1:0]      disp_tagy;
    logic [WORD_WIDTH-1:0] disp_datax;
    logic [WORD_WIDTH-1:0] disp_datay;
    logic [REG_WIDTH-1:0]  disp_target;
    logic                  full;

    logic                  cdb0_en;
    logic [TAG_W-1:0]      cdb0_tag;
    logic [WORD_WIDTH-1:0] cdb0_data;
    logic                  cdb1_en;
    logic [TAG_W-1:0]      cdb1_tag;
    logic [WORD_WIDTH-1:0] cdb1_data;

    logic                  iss_busy;
    logic [OP_W-1:0]       iss_op;
    logic [ADDR_WIDTH-1:0] iss_pc;
    logic [TAG_W-1:0]      iss_tagx;
    logic [TAG_W-1:0]      iss_tagy;
    logic [TAG_W-1:0]      iss_tagw;
    logic [WORD_WIDTH-1:0] iss_datax;
    logic [WORD_WIDTH-1:0] iss_datay;
    logic [REG_WIDTH-1:0]  iss_target;
    logic                  iss_ack;

    // Station side.
    modport slave (
        input  rdy, flush,
        input  disp_en, disp_op, disp_pc, disp_tagx, disp_tagy, disp_datax, disp_datay, disp_target,
        output full,
        input  cdb0_en, cdb0_tag, cdb0_data, cdb1_en, cdb1_tag, cdb1_data,
        output iss_busy, iss_op, iss_pc, iss_tagx, iss_tagy, iss_tagw, iss_datax, iss_datay, iss_target,
        input  iss_ack
    );

    // Pipeline side (dispatch, writeback, ALU).
    modport master (
        output rdy, flush,
        output disp_en, disp_op, disp_pc, disp_tagx, disp_tagy, disp_datax, disp_datay, disp_target,
        input  full,
        output cdb0_en, cdb0_tag, cdb0_data, cdb1_en, cdb1_tag, cdb1_data,
        input  iss_busy, iss_op, iss_pc, iss_tagx, iss_tagy, iss_tagw, iss_datax, iss_datay, iss_target,
        output iss_ack
    );

endinterface

// File: rtl/alu_rs_entry.sv
// One reservation-station slot: holds an op and snoops both CDBs until its operands are present.
module alu_rs_entry import alu_rs_pkg::*; #(
    parameter int TAG_W = TAG_WIDTH,
    parameter int OP_W  = OP_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_en,
    input  logic                  i_flush,
    input  logic                  i_load,
    input  logic [OP_W-1:0]       i_op,
    input  logic [ADDR_WIDTH-1:0] i_pc,
    input  logic [TAG_W-1:0]      i_tagx,
    input  logic [TAG_W-1:0]      i_tagy,
    input  logic [WORD_WIDTH-1:0] i_datax,
    input  logic [WORD_WIDTH-1:0] i_datay,
    input  logic [REG_WIDTH-1:0]  i_target,
    input  logic                  i_cdb0_en,
    input  logic [TAG_W-1:0]      i_cdb0_tag,
    input  logic [WORD_WIDTH-1:0] i_cdb0_data,
    input  logic                  i_cdb1_en,
    input  logic [TAG_W-1:0]      i_cdb1_tag,
    input  logic [WORD_WIDTH-1:0] i_cdb1_data,
    input  logic                  i_clear,
    output logic                  o_valid,
    output logic                  o_ready,
    output logic [OP_W-1:0]       o_op,
    output logic [ADDR_WIDTH-1:0] o_pc,
    output logic [WORD_WIDTH-1:0] o_datax,
    output logic [WORD_WIDTH-1:0] o_datay,
    output logic [REG_WIDTH-1:0]  o_target
);

    localparam logic [TAG_W-1:0] TAG_UNLOCKED = TAG_W'(UNLOCKED);

    logic                  r_valid;
    logic [OP_W-1:0]       r_op;
    logic [ADDR_WIDTH-1:0] r_pc;
    logic [TAG_W-1:0]      r_tagx;
    logic [TAG_W-1:0]      r_tagy;
    logic [WORD_WIDTH-1:0] r_datax;
    logic [WORD_WIDTH-1:0] r_datay;
    logic [REG_WIDTH-1:0]  r_target;

    logic [TAG_W-1:0]      w_src_tagx;
    logic [TAG_W-1:0]      w_src_tagy;
    logic [WORD_WIDTH-1:0] w_src_datax;
    logic [WORD_WIDTH-1:0] w_src_datay;
    logic [TAG_W-1:0]      w_next_tagx;
    logic [TAG_W-1:0]      w_next_tagy;
    logic [WORD_WIDTH-1:0] w_next_datax;
    logic [WORD_WIDTH-1:0] w_next_datay;

    // Resolve one source against both buses; cdb0 wins when both carry the tag.
    function automatic logic [TAG_W+WORD_WIDTH-1:0] snoop(
        input logic [TAG_W-1:0]      tag,
        input logic [WORD_WIDTH-1:0] data,
        input logic                  c0_en,
        input logic [TAG_W-1:0]      c0_tag,
        input logic [WORD_WIDTH-1:0] c0_data,
        input logic                  c1_en,
        input logic [TAG_W-1:0]      c1_tag,
        input logic [WORD_WIDTH-1:0] c1_data
    );
        if (tag != TAG_UNLOCKED && c0_en && c0_tag == tag) return {TAG_UNLOCKED, c0_data};
        if (tag != TAG_UNLOCKED && c1_en && c1_tag == tag) return {TAG_UNLOCKED, c1_data};
        return {tag, data};
    endfunction

    // Dispatch bypass and wakeup share one snoop path: the source is the incoming op or the stored one.
    assign w_src_tagx  = i_load ? i_tagx  : r_tagx;
    assign w_src_tagy  = i_load ? i_tagy  : r_tagy;
    assign w_src_datax = i_load ? i_datax : r_datax;
    assign w_src_datay = i_load ? i_datay : r_datay;

    assign {w_next_tagx, w_next_datax} = snoop(w_src_tagx, w_src_datax, i_cdb0_en, i_cdb0_tag,
                                               i_cdb0_data, i_cdb1_en, i_cdb1_tag, i_cdb1_data);
    assign {w_next_tagy, w_next_datay} = snoop(w_src_tagy, w_src_datay, i_cdb0_en, i_cdb0_tag,
                                               i_cdb0_data, i_cdb1_en, i_cdb1_tag, i_cdb1_data);

    // Slot occupancy: set on dispatch, cleared on issue, flush or reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
        if (rst) begin
            r_valid <= 1'b0;
        end else if (i_en) begin
            if (i_flush || i_clear) r_valid <= 1'b0;
            else if (i_load)        r_valid <= 1'b1;
        end
    end

    // Payload capture on dispatch, then operand wakeup while the slot is occupied.
    always_ff @(posedge clk) begin
        // NOTE: payload is deliberately not reset; r_valid alone qualifies it.
        if (i_en && (i_load || r_valid)) begin
            r_tagx  <= w_next_tagx;
            r_tagy  <= w_next_tagy;
            r_datax <= w_next_datax;
            r_datay <= w_next_datay;
            if (i_load) begin
                r_op     <= i_op;
                r_pc     <= i_pc;
                r_target <= i_target;
            end
        end
    end

    assign o_valid  = r_valid;
    assign o_ready  = r_valid && (r_tagx == TAG_UNLOCKED) && (r_tagy == TAG_UNLOCKED);
    assign o_op     = r_op;
    assign o_pc     = r_pc;
    assign o_datax  = r_datax;
    assign o_datay  = r_datay;
    assign o_target = r_target;

endmodule

// File: rtl/alu_rs.sv
// ALU reservation station: DEPTH slots, lowest-free dispatch, lowest-ready issue into a registered port.
module alu_rs import alu_rs_pkg::*; #(
    parameter int DEPTH = 4,
    parameter int TAG_W = TAG_WIDTH,
    parameter int OP_W  = OP_WIDTH
) (
    input logic     clk,
    input logic     rst,
    alu_rs_if.slave bus
);

    localparam int               IDX_W        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [TAG_W-1:0] TAG_UNLOCKED = TAG_W'(UNLOCKED);

    logic [DEPTH-1:0]      w_valid;
    logic [DEPTH-1:0]      w_ready;
    logic [DEPTH-1:0]      w_load;
    logic [DEPTH-1:0]      w_clear;
    logic [OP_W-1:0]       w_op     [DEPTH];
    logic [ADDR_WIDTH-1:0] w_pc     [DEPTH];
    logic [WORD_WIDTH-1:0] w_datax  [DEPTH];
    logic [WORD_WIDTH-1:0] w_datay  [DEPTH];
    logic [REG_WIDTH-1:0]  w_target [DEPTH];

    logic                  w_free_found;
    logic [IDX_W-1:0]      w_free_idx;
    logic                  w_rdy_found;
    logic [IDX_W-1:0]      w_rdy_idx;
    logic                  w_disp_accept;
    logic                  w_iss_open;
    logic                  w_issue;

    logic                  r_iss_busy;
    logic [OP_W-1:0]       r_iss_op;
    logic [ADDR_WIDTH-1:0] r_iss_pc;
    logic [WORD_WIDTH-1:0] r_iss_datax;
    logic [WORD_WIDTH-1:0] r_iss_datay;
    logic [REG_WIDTH-1:0]  r_iss_target;

    // Lowest-index free slot for dispatch and lowest-index ready slot for issue.
    always_comb begin
        // NOTE: defaults come first so every path assigns every output and no latch is inferred.
        w_free_found = 1'b0;
        w_free_idx   = '0;
        w_rdy_found  = 1'b0;
        w_rdy_idx    = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!w_valid[i]) begin
                w_free_found = 1'b1;
                w_free_idx   = IDX_W'(i);
            end
            if (w_ready[i]) begin
                w_rdy_found = 1'b1;
                w_rdy_idx   = IDX_W'(i);
            end
        end
    end

    // Full is taken from pre-edge state, so a same-cycle issue never opens a slot for dispatch.
    assign bus.full      = &w_valid;
    assign w_disp_accept = bus.disp_en && w_free_found && !bus.flush;
    assign w_iss_open    = !r_iss_busy || bus.iss_ack;
    assign w_issue       = w_iss_open && w_rdy_found && !bus.flush;

    for (genvar g = 0; g < DEPTH; g++) begin : g_entry
        assign w_load[g]  = w_disp_accept && (w_free_idx == IDX_W'(g));
        assign w_clear[g] = w_issue && (w_rdy_idx == IDX_W'(g));

        alu_rs_entry #(.TAG_W(TAG_W), .OP_W(OP_W)) u_entry (
            .clk         (clk),
            .rst         (rst),
            .i_en        (bus.rdy),
            .i_flush     (bus.flush),
            .i_load      (w_load[g]),
            .i_op        (bus.disp_op),
            .i_pc        (bus.disp_pc),
            .i_tagx      (bus.disp_tagx),
            .i_tagy      (bus.disp_tagy),
            .i_datax     (bus.disp_datax),
            .i_datay     (bus.disp_datay),
            .i_target    (bus.disp_target),
            .i_cdb0_en   (bus.cdb0_en),
            .i_cdb0_tag  (bus.cdb0_tag),
            .i_cdb0_data (bus.cdb0_data),
            .i_cdb1_en   (bus.cdb1_en),
            .i_cdb1_tag  (bus.cdb1_tag),
            .i_cdb1_data (bus.cdb1_data),
            .i_clear     (w_clear[g]),
            .o_valid     (w_valid[g]),
            .o_ready     (w_ready[g]),
            .o_op        (w_op[g]),
            .o_pc        (w_pc[g]),
            .o_datax     (w_datax[g]),
            .o_datay     (w_datay[g]),
            .o_target    (w_target[g])
        );
    end

    // Issue register: refill from the lowest ready slot whenever it is empty or being acknowledged.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_iss_busy   <= 1'b0;
            r_iss_op     <= '0;
            r_iss_pc     <= '0;
            r_iss_datax  <= ZERO;
            r_iss_datay  <= ZERO;
            r_iss_target <= '0;
        end else if (bus.rdy) begin
            if (bus.flush) begin
                r_iss_busy <= 1'b0;
            end else if (w_iss_open) begin
                r_iss_busy <= w_rdy_found;
                if (w_rdy_found) begin
                    r_iss_op     <= w_op[w_rdy_idx];
                    r_iss_pc     <= w_pc[w_rdy_idx];
                    r_iss_datax  <= w_datax[w_rdy_idx];
                    r_iss_datay  <= w_datay[w_rdy_idx];
                    r_iss_target <= w_target[w_rdy_idx];
                end
            end
        end
    end

    // Only fully resolved ops reach the issue register, so its tags are UNLOCKED by construction.
    assign bus.iss_busy   = r_iss_busy;
    assign bus.iss_op     = r_iss_op;
    assign bus.iss_pc     = r_iss_pc;
    assign bus.iss_tagx   = TAG_UNLOCKED;
    assign bus.iss_tagy   = TAG_UNLOCKED;
    assign bus.iss_tagw   = TAG_UNLOCKED;
    assign bus.iss_datax  = r_iss_datax;
    assign bus.iss_datay  = r_iss_datay;
    assign bus.iss_target = r_iss_target;

    // A dispatch presented to a full station is dropped; flag it so the upstream stall bug is visible.
    assert property (@(posedge clk) disable iff (rst)
        !(bus.rdy && !bus.flush && bus.disp_en && bus.full))
        else $warning("alu_rs: dispatch dropped while station full");

endmodule

// File: tb/tb_alu_rs.sv
// Directed testbench for alu_rs: reset, issue latency, wakeup, bypass, full, backpressure, flush, rdy.
module tb_alu_rs;
    import alu_rs_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;

    alu_rs_if #(.TAG_W(5), .OP_W(6)) bus ();

    alu_rs #(.DEPTH(4), .TAG_W(5), .OP_W(6)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Advance one edge and settle, so outputs are sampled away from the clock edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.flush       = 1'b0;
        bus.disp_en     = 1'b0;
        bus.disp_op     = '0;
        bus.disp_pc     = '0;
        bus.disp_tagx   = '0;
        bus.disp_tagy   = '0;
        bus.disp_datax  = '0;
        bus.disp_datay  = '0;
        bus.disp_target = '0;
        bus.cdb0_en     = 1'b0;
        bus.cdb0_tag    = '0;
        bus.cdb0_data   = '0;
        bus.cdb1_en     = 1'b0;
        bus.cdb1_tag    = '0;
        bus.cdb1_data   = '0;
    endtask

    task automatic drive_disp(input logic [5:0] op, input logic [31:0] pc, input logic [4:0] tx,
                              input logic [4:0] ty, input logic [31:0] dx, input logic [31:0] dy,
                              input logic [4:0] tgt);
        bus.disp_en     = 1'b1;
        bus.disp_op     = op;
        bus.disp_pc     = pc;
        bus.disp_tagx   = tx;
        bus.disp_tagy   = ty;
        bus.disp_datax  = dx;
        bus.disp_datay  = dy;
        bus.disp_target = tgt;
    endtask

    task automatic test_reset();
        idle();
        bus.rdy     = 1'b0;
        bus.iss_ack = 1'b1;
        rst         = 1'b1;
        tick();
        tick();
        rst     = 1'b0;
        bus.rdy = 1'b1;
        n_tests++; if (bus.iss_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0b want 0", bus.iss_busy); end
        n_tests++; if (bus.full !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %0b want 0", bus.full); end
        n_tests++; if (bus.iss_op !== 6'd0 || bus.iss_pc !== 32'd0 || bus.iss_target !== 5'd0) begin n_fail++;
            $display("FAIL reset_fields: op=%0h pc=%0h tgt=%0h want 0", bus.iss_op, bus.iss_pc, bus.iss_target); end
        n_tests++; if (bus.iss_datax !== 32'd0 || bus.iss_datay !== 32'd0) begin n_fail++;
            $display("FAIL reset_data: x=%0h y=%0h want 0", bus.iss_datax, bus.iss_datay); end
        n_tests++; if (bus.iss_tagx !== 5'd0 || bus.iss_tagy !== 5'd0 || bus.iss_tagw !== 5'd0) begin n_fail++;
            $display("FAIL reset_tags: %0h %0h %0h want 0", bus.iss_tagx, bus.iss_tagy, bus.iss_tagw); end
    endtask

    task automatic test_basic();
        bus.iss_ack = 1'b1;
        drive_disp(ALU_ADD, 32'h100, 5'd0, 5'd0, 32'd3, 32'd4, 5'd5);
        tick();
        idle();
        n_tests++; if (bus.iss_busy !== 1'b0) begin n_fail++; $display("FAIL basic_early: busy=%0b want 0", bus.iss_busy); end
        tick();
        n_tests++; if (bus.iss_busy !== 1'b1 || bus.iss_op !== ALU_ADD || bus.iss_pc !== 32'h100) begin n_fail++;
            $display("FAIL basic_issue: busy=%0b op=%0h pc=%0h want 1/1/100", bus.iss_busy, bus.iss_op, bus.iss_pc); end
        n_tests++; if (bus.iss_datax !== 32'd3 || bus.iss_datay !== 32'd4 || bus.iss_target !== 5'd5) begin n_fail++;
            $display("FAIL basic_data: x=%0h y=%0h tgt=%0h want 3/4/5", bus.iss_datax, bus.iss_datay, bus.iss_target); end
        tick();
        n_tests++; if (bus.iss_busy !== 1'b0) begin n_fail++; $display("FAIL basic_drain: busy=%0b want 0", bus.iss_busy); end
    endtask

    task automatic test_wakeup();
        bus.iss_ack = 1'b1;
        drive_disp(ALU_SUB, 32'h200, 5'd7, 5'd0, 32'd0, 32'h20, 5'd6);
        tick();
        idle();
        tick();
        n_tests++; if (bus.iss_busy !== 1'b0) begin n_fail++; $display("FAIL wake_wait: busy=%0b want 0", bus.iss_busy); end
        bus.cdb0_en = 1'b1; bus.cdb0_tag = 5'd7; bus.cdb0_data = 32'h10;
        tick();
        idle();
        n_tests++; if (bus.iss_busy !== 1'b0) begin n_fail++; $display("FAIL wake_edge: busy=%0b want 0", bus.iss_busy); end
        tick();
        n_tests++; if (bus.iss_busy !== 1'b1 || bus.iss_datax !== 32'h10 || bus.iss_datay !== 32'h20 || bus.iss_op !== ALU_SUB) begin n_fail++;
            $display("FAIL wake_issue: busy=%0b x=%0h y=%0h op=%0h want 1/10/20/2", bus.iss_busy, bus.iss_datax, bus.iss_datay, bus.iss_op); end
        tick();
        // Both buses carry the awaited tag: cdb0 must win.
        drive_disp(ALU_OR, 32'h210, 5'd12, 5'd0, 32'd0, 32'd1, 5'd8);
        tick();
        idle();
        bus.cdb0_en = 1'b1; bus.cdb0_tag = 5'd12; bus.cdb0_data = 32'hC0;
        bus.cdb1_en = 1'b1; bus.cdb1_tag = 5'd12; bus.cdb1_data = 32'hC1;
        tick();
        idle();
        tick();
        n_tests++; if (bus.iss_busy !== 1'b1 || bus.iss_datax !== 32'hC0) begin n_fail++;
            $display("FAIL wake_dual: busy=%0b x=%0h want 1/c0", bus.iss_busy, bus.iss_datax); end
        tick();
    endtask

    task automatic test_bypass();
        bus.iss_ack = 1'b1;
        drive_disp(ALU_XOR, 32'h300, 5'd0, 5'd9, 32'd5, 32'd0, 5'd7);
        bus.cdb1_en = 1'b1; bus.cdb1_tag = 5'd9; bus.cdb1_data = 32'hAB;
        tick();
        idle();
        tick();
        n_tests++; if (bus.iss_busy !== 1'b1 || bus.iss_datay !== 32'hAB || bus.iss_datax !== 32'd5) begin n_fail++;
            $display("FAIL bypass: busy=%0b x=%0h y=%0h want 1/5/ab", bus.iss_busy, bus.iss_datax, bus.iss_datay); end
        tick();
        n_tests++; if (bus.iss_busy !== 1'b0) begin n_fail++; $display("FAIL bypass_drain: busy=%0b want 0", bus.iss_busy); end
    endtask

    task automatic test_full();
        bus.iss_ack = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive_disp(ALU_AND, 32'h400 + 32'(4 * i), 5'd3, 5'd0, 32'd0, 32'(i + 1), 5'(i + 1));
            tick();
            n_tests++; if (bus.full !== (i == 3)) begin n_fail++; $display("FAIL full_fill%0d: full=%0b want %0b", i, bus.full, (i == 3)); end
        end
        drive_disp(ALU_AND, 32'h4F0, 5'd3, 5'd0, 32'd0, 32'd99, 5'd31);
        tick();
        idle();
        n_tests++; if (bus.full !== 1'b1 || bus.iss_busy !== 1'b0) begin n_fail++;
            $display("FAIL full_drop: full=%0b busy=%0b want 1/0", bus.full, bus.iss_busy); end
        bus.cdb0_en = 1'b1; bus.cdb0_tag = 5'd3; bus.cdb0_data = 32'h33;
        tick();
        idle();
        n_tests++; if (bus.full !== 1'b1 || bus.iss_busy !== 1'b0) begin n_fail++;
            $display("FAIL full_wake: full=%0b busy=%0b want 1/0", bus.full, bus.iss_busy); end
        for (int i = 0; i < 4; i++) begin
            tick();
            n_tests++; if (bus.iss_busy !== 1'b1 || bus.iss_target !== 5'(i + 1) || bus.iss_datax !== 32'h33 ||
                           bus.iss_datay !== 32'(i + 1) || bus.full !== 1'b0) begin n_fail++;
                $display("FAIL full_issue%0d: busy=%0b tgt=%0d x=%0h y=%0h full=%0b want 1/%0d/33/%0h/0", i, bus.iss_busy,
                         bus.iss_target, bus.iss_datax, bus.iss_datay, bus.full, i + 1, i + 1); end
        end
        tick();
        n_tests++; if (bus.iss_busy !== 1'b0 || bus.full !== 1'b0) begin n_fail++;
            $display("FAIL full_drain: busy=%0b full=%0b want 0/0", bus.iss_busy, bus.full); end
    endtask

    task automatic test_backpressure();
        bus.iss_ack = 1'b0;
        drive_disp(ALU_ADD, 32'h500, 5'd0, 5'd0, 32'd1, 32'd1, 5'd10);
        tick();
        drive_disp(ALU_ADD, 32'h504, 5'd0, 5'd0, 32'd2, 32'd2, 5'd11);
        tick();
        idle();
        n_tests++; if (bus.iss_busy !== 1'b1 || bus.iss_target !== 5'd10) begin n_fail++;
            $display("FAIL bp_first: busy=%0b tgt=%0d want 1/10", bus.iss_busy, bus.iss_target); end
        for (int i = 0; i < 2; i++) begin
            tick();
            n_tests++; if (bus.iss_busy !== 1'b1 || bus.iss_target !== 5'd10 || bus.iss_datax !== 32'd1) begin n_fail++;
                $display("FAIL bp_hold%0d: busy=%0b tgt=%0d x=%0h want 1/10/1", i, bus.iss_busy, bus.iss_target, bus.iss_datax); end
        end
        bus.iss_ack = 1'b1;
        tick();
        n_tests++; if (bus.iss_busy !== 1'b1 || bus.iss_target !== 5'd11 || bus.iss_datax !== 32'd2) begin n_fail++;
            $display("FAIL bp_next: busy=%0b tgt=%0d x=%0h want 1/11/2", bus.iss_busy, bus.iss_target, bus.iss_datax); end
        tick();
        n_tests++; if (bus.iss_busy !== 1'b0) begin n_fail++; $display("FAIL bp_drain: busy=%0b want 0", bus.iss_busy); end
    endtask

    task automatic test_flush();
        bus.iss_ack = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive_disp(ALU_ADD, 32'h600 + 32'(4 * i), 5'd0, 5'd0, 32'(i), 32'd0, 5'(20 + i));
            tick();
        end
        n_tests++; if (bus.full !== 1'b1 || bus.iss_busy !== 1'b1 || bus.iss_target !== 5'd20) begin n_fail++;
            $display("FAIL flush_pre: full=%0b busy=%0b tgt=%0d want 1/1/20", bus.full, bus.iss_busy, bus.iss_target); end
        drive_disp(ALU_ADD, 32'h6F0, 5'd0, 5'd0, 32'd7, 32'd7, 5'd30);
        bus.flush   = 1'b1;
        bus.iss_ack = 1'b1;
        tick();
        idle();
        n_tests++; if (bus.full !== 1'b0 || bus.iss_busy !== 1'b0) begin n_fail++;
            $display("FAIL flush_clear: full=%0b busy=%0b want 0/0", bus.full, bus.iss_busy); end
        for (int i = 0; i < 2; i++) begin
            tick();
            n_tests++; if (bus.full !== 1'b0 || bus.iss_busy !== 1'b0) begin n_fail++;
                $display("FAIL flush_empty%0d: full=%0b busy=%0b want 0/0", i, bus.full, bus.iss_busy); end
        end
    endtask

    task automatic test_rdy_rst();
        bus.iss_ack = 1'b0;
        drive_disp(ALU_ADD, 32'h700, 5'd0, 5'd0, 32'h77, 32'd0, 5'd25);
        tick();
        drive_disp(ALU_ADD, 32'h704, 5'd0, 5'd0, 32'h78, 32'd0, 5'd26);
        tick();
        idle();
        bus.rdy     = 1'b0;
        bus.iss_ack = 1'b1;
        tick();
        n_tests++; if (bus.iss_busy !== 1'b1 || bus.iss_target !== 5'd25 || bus.iss_datax !== 32'h77) begin n_fail++;
            $display("FAIL rdy_hold: busy=%0b tgt=%0d x=%0h want 1/25/77", bus.iss_busy, bus.iss_target, bus.iss_datax); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_tests++; if (bus.iss_busy !== 1'b0 || bus.full !== 1'b0 || bus.iss_target !== 5'd0 || bus.iss_datax !== 32'd0) begin n_fail++;
            $display("FAIL rdy_rst: busy=%0b full=%0b tgt=%0d x=%0h want 0/0/0/0", bus.iss_busy, bus.full, bus.iss_target, bus.iss_datax); end
        tick();
        bus.rdy = 1'b1;
        tick();
        n_tests++; if (bus.iss_busy !== 1'b0) begin n_fail++; $display("FAIL rdy_rst_empty: busy=%0b want 0", bus.iss_busy); end
    endtask

    initial begin
        rst = 1'b1;
        idle();
        bus.rdy     = 1'b0;
        bus.iss_ack = 1'b1;
        test_reset();
        test_basic();
        test_wakeup();
        test_bypass();
        test_full();
        test_backpressure();
        test_flush();
        test_rdy_rst();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish by %0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
